// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types, response codes and arbiter state encoding.
// TO_RESP exists only when AXIL_ARB_TIMEOUT_EN is defined.
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0]   addr_t;
  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [DATA_W/8-1:0] strb_t;
  typedef logic [1:0]          resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_DATA,
    WR_RESP
`ifdef AXIL_ARB_TIMEOUT_EN
    , TO_RESP
`endif
  } arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle with master and slave views.
// Carries the five channels without protection bits.
interface axi_lite_if;
  import axi_lite_pkg::*;

  addr_t awaddr;
  logic  awvalid;
  logic  awready;
  data_t wdata;
  strb_t wstrb;
  logic  wvalid;
  logic  wready;
  resp_t bresp;
  logic  bvalid;
  logic  bready;
  addr_t araddr;
  logic  arvalid;
  logic  arready;
  data_t rdata;
  resp_t rresp;
  logic  rvalid;
  logic  rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr.
// The search wraps modulo NUM_M.
module axi_lite_rr_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int NUM_M = 2,
  localparam int IDX_W = idx_w(NUM_M)
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_any,
  output logic [IDX_W-1:0] o_win
);
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_M);

  logic [IDX_W:0] w_idx;

  always_comb begin
    o_any = 1'b0;
    o_win = '0;
    w_idx = '0;
    for (int k = 0; k < NUM_M; k++) begin
      w_idx = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_idx >= NUM_L)
        w_idx = w_idx - NUM_L;
      if (!o_any && i_req[w_idx[IDX_W-1:0]]) begin
        o_any = 1'b1;
        o_win = w_idx[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/axi_lite_arbiter.sv
// Serialises AXI4-Lite transactions from NUM_M masters onto one slave.
// Optional response watchdog: define AXIL_ARB_TIMEOUT_EN.
module axi_lite_arbiter
  import axi_lite_pkg::*;
#(
  parameter  int NUM_M       = 2,
  parameter  int TIMEOUT_CYC = 256,
  localparam int IDX_W       = idx_w(NUM_M)
) (
  input  logic             aclk,
  input  logic             areset_n,
  axi_lite_if.slave        s_axi [NUM_M],
  axi_lite_if.master       m_axi,
  output logic [IDX_W-1:0] gnt_id,
  output logic             busy,
  output logic             timeout_o
);
  localparam logic [IDX_W:0] NUM_L = (IDX_W+1)'(NUM_M);

  arb_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0] r_gnt, r_ptr, w_win, w_ptr_nxt;
  logic [IDX_W:0]   w_inc;
  logic             w_any;

  logic [NUM_M-1:0] w_arv, w_awv, w_wv, w_rrdy, w_brdy;
  logic [NUM_M-1:0] w_req, w_sel;
  addr_t w_araddr [NUM_M];
  addr_t w_awaddr [NUM_M];
  data_t w_wdata  [NUM_M];
  strb_t w_wstrb  [NUM_M];

  logic [NUM_M-1:0] w_s_arrdy, w_s_awrdy, w_s_wrdy;
  logic [NUM_M-1:0] w_s_rv, w_s_bv;
  data_t w_s_rdata [NUM_M];
  resp_t w_s_rresp [NUM_M];
  resp_t w_s_bresp [NUM_M];

  logic w_rd_a, w_rd_d, w_wr_a, w_wr_d, w_wr_r;
  logic w_to_r, w_to_b;
  logic w_m_arv, w_m_awv, w_m_wv, w_m_rrdy, w_m_brdy;
  logic w_ar_hs, w_aw_hs, w_w_hs, w_r_hs, w_b_hs;

  for (genvar i = 0; i < NUM_M; i++) begin : g_port
    assign w_arv[i]    = s_axi[i].arvalid;
    assign w_awv[i]    = s_axi[i].awvalid;
    assign w_wv[i]     = s_axi[i].wvalid;
    assign w_rrdy[i]   = s_axi[i].rready;
    assign w_brdy[i]   = s_axi[i].bready;
    assign w_araddr[i] = s_axi[i].araddr;
    assign w_awaddr[i] = s_axi[i].awaddr;
    assign w_wdata[i]  = s_axi[i].wdata;
    assign w_wstrb[i]  = s_axi[i].wstrb;

    assign s_axi[i].arready = w_s_arrdy[i];
    assign s_axi[i].awready = w_s_awrdy[i];
    assign s_axi[i].wready  = w_s_wrdy[i];
    assign s_axi[i].rvalid  = w_s_rv[i];
    assign s_axi[i].rdata   = w_s_rdata[i];
    assign s_axi[i].rresp   = w_s_rresp[i];
    assign s_axi[i].bvalid  = w_s_bv[i];
    assign s_axi[i].bresp   = w_s_bresp[i];
  end

  assign w_req = w_arv | w_awv;

  axi_lite_rr_arbiter #(.NUM_M(NUM_M)) u_rr (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_win (w_win)
  );

  always_comb begin
    w_inc = {1'b0, w_win} + 1'b1;
    if (w_inc >= NUM_L)
      w_inc = '0;
    w_ptr_nxt = w_inc[IDX_W-1:0];
  end

  assign w_rd_a = (r_state == RD_ADDR);
  assign w_rd_d = (r_state == RD_DATA);
  assign w_wr_a = (r_state == WR_ADDR);
  assign w_wr_d = (r_state == WR_DATA);
  assign w_wr_r = (r_state == WR_RESP);

  assign w_m_arv  = w_rd_a & w_arv[r_gnt];
  assign w_m_awv  = w_wr_a & w_awv[r_gnt];
  assign w_m_wv   = w_wr_d & w_wv[r_gnt];
  assign w_m_rrdy = w_rd_d & w_rrdy[r_gnt];
  assign w_m_brdy = w_wr_r & w_brdy[r_gnt];

  assign m_axi.arvalid = w_m_arv;
  assign m_axi.araddr  = w_araddr[r_gnt];
  assign m_axi.awvalid = w_m_awv;
  assign m_axi.awaddr  = w_awaddr[r_gnt];
  assign m_axi.wvalid  = w_m_wv;
  assign m_axi.wdata   = w_wdata[r_gnt];
  assign m_axi.wstrb   = w_wstrb[r_gnt];
  assign m_axi.rready  = w_m_rrdy;
  assign m_axi.bready  = w_m_brdy;

  assign w_ar_hs = w_m_arv & m_axi.arready;
  assign w_aw_hs = w_m_awv & m_axi.awready;
  assign w_w_hs  = w_m_wv & m_axi.wready;
  assign w_r_hs  = m_axi.rvalid & w_m_rrdy;
  assign w_b_hs  = m_axi.bvalid & w_m_brdy;

  always_comb begin
    w_sel = '0;
    w_sel[r_gnt] = 1'b1;
    for (int i = 0; i < NUM_M; i++) begin
      w_s_arrdy[i] = w_sel[i] & w_rd_a & m_axi.arready;
      w_s_awrdy[i] = w_sel[i] & w_wr_a & m_axi.awready;
      w_s_wrdy[i]  = w_sel[i] & w_wr_d & m_axi.wready;
      w_s_rv[i]    = w_sel[i] & ((w_rd_d & m_axi.rvalid) | w_to_r);
      w_s_bv[i]    = w_sel[i] & ((w_wr_r & m_axi.bvalid) | w_to_b);
      w_s_rdata[i] = (w_sel[i] & w_rd_d) ? m_axi.rdata : '0;
      w_s_rresp[i] = (w_sel[i] & w_rd_d) ? m_axi.rresp :
                     (w_sel[i] & w_to_r) ? RESP_SLVERR : RESP_OKAY;
      w_s_bresp[i] = (w_sel[i] & w_wr_r) ? m_axi.bresp :
                     (w_sel[i] & w_to_b) ? RESP_SLVERR : RESP_OKAY;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TO_L = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic             r_to_rd, r_timeout, w_go_to;

  assign w_to_r    = (r_state == TO_RESP) & r_to_rd;
  assign w_to_b    = (r_state == TO_RESP) & ~r_to_rd;
  assign timeout_o = r_timeout;
`else
  assign w_to_r    = 1'b0;
  assign w_to_b    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
`ifdef AXIL_ARB_TIMEOUT_EN
    w_go_to = 1'b0;
`endif
    unique case (r_state)
      IDLE:
        if (w_any)
          w_state_nxt = w_arv[w_win] ? RD_ADDR : WR_ADDR;
      RD_ADDR:
        if (w_ar_hs) w_state_nxt = RD_DATA;
      RD_DATA:
        if (w_r_hs) w_state_nxt = IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (r_cnt == TO_L) begin
          w_state_nxt = TO_RESP;
          w_go_to     = 1'b1;
        end
`endif
      WR_ADDR:
        if (w_aw_hs) w_state_nxt = WR_DATA;
      WR_DATA:
        if (w_w_hs) w_state_nxt = WR_RESP;
      WR_RESP:
        if (w_b_hs) w_state_nxt = IDLE;
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (r_cnt == TO_L) begin
          w_state_nxt = TO_RESP;
          w_go_to     = 1'b1;
        end
      TO_RESP:
        if (r_to_rd ? w_rrdy[r_gnt] : w_brdy[r_gnt])
          w_state_nxt = IDLE;
`endif
      default:
        w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_any) begin
        r_gnt <= w_win;
        r_ptr <= w_ptr_nxt;
      end
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  // Counts only cycles the slave leaves its response valid low.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      r_cnt     <= '0;
      r_to_rd   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_go_to;
      if (w_go_to)
        r_to_rd <= w_rd_d;
      if (w_state_nxt != r_state &&
          (w_state_nxt == RD_DATA || w_state_nxt == WR_RESP))
        r_cnt <= '0;
      else if ((w_rd_d & ~m_axi.rvalid) | (w_wr_r & ~m_axi.bvalid))
        r_cnt <= r_cnt + 1'b1;
    end
  end
`endif

  assign busy   = (r_state != IDLE);
  assign gnt_id = r_gnt;
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter with two masters and a memory slave.
// Watchdog step runs only when AXIL_ARB_TIMEOUT_EN is defined.
module tb_axi_lite_arbiter;
  import axi_lite_pkg::*;

  logic       aclk;
  logic       areset_n;
  logic [0:0] gnt_id;
  logic       busy;
  logic       timeout_o;

  axi_lite_if s_if [2] ();
  axi_lite_if m_if ();

  axi_lite_arbiter #(.NUM_M(2), .TIMEOUT_CYC(256)) dut (
    .aclk      (aclk),
    .areset_n  (areset_n),
    .s_axi     (s_if),
    .m_axi     (m_if),
    .gnt_id    (gnt_id),
    .busy      (busy),
    .timeout_o (timeout_o)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [1:0]  m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [31:0] m_araddr [2];
  logic [31:0] m_awaddr [2];
  logic [31:0] m_wdata  [2];
  logic [1:0]  s_arready, s_awready, s_wready, s_rvalid, s_bvalid;
  logic [31:0] s_rdata  [2];
  logic [1:0]  s_rresp  [2];
  logic [1:0]  s_bresp  [2];

  for (genvar g = 0; g < 2; g++) begin : g_m
    assign s_if[g].arvalid = m_arvalid[g];
    assign s_if[g].araddr  = m_araddr[g];
    assign s_if[g].awvalid = m_awvalid[g];
    assign s_if[g].awaddr  = m_awaddr[g];
    assign s_if[g].wvalid  = m_wvalid[g];
    assign s_if[g].wdata   = m_wdata[g];
    assign s_if[g].wstrb   = 4'hF;
    assign s_if[g].rready  = m_rready[g];
    assign s_if[g].bready  = m_bready[g];
    assign s_arready[g] = s_if[g].arready;
    assign s_awready[g] = s_if[g].awready;
    assign s_wready[g]  = s_if[g].wready;
    assign s_rvalid[g]  = s_if[g].rvalid;
    assign s_bvalid[g]  = s_if[g].bvalid;
    assign s_rdata[g]   = s_if[g].rdata;
    assign s_rresp[g]   = s_if[g].rresp;
    assign s_bresp[g]   = s_if[g].bresp;
  end

  // Memory slave: AR/AW/W always ready unless stalled, R/B one cycle later.
  logic        sl_awready, sl_no_b, sl_rvalid, sl_bvalid;
  logic [31:0] sl_rdata, sl_awaddr;
  logic [31:0] mem [16];

  assign m_if.arready = 1'b1;
  assign m_if.awready = sl_awready;
  assign m_if.wready  = 1'b1;
  assign m_if.rvalid  = sl_rvalid;
  assign m_if.rdata   = sl_rdata;
  assign m_if.rresp   = RESP_OKAY;
  assign m_if.bvalid  = sl_bvalid;
  assign m_if.bresp   = RESP_OKAY;

  always @(posedge aclk) begin
    if (!areset_n) begin
      sl_rvalid <= 1'b0;
      sl_bvalid <= 1'b0;
      sl_rdata  <= '0;
      sl_awaddr <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      mem[1] <= 32'hDEADBEEF;
      mem[3] <= 32'hCAFEF00D;
    end else begin
      if (m_if.arvalid && m_if.arready) begin
        sl_rvalid <= 1'b1;
        sl_rdata  <= mem[m_if.araddr[5:2]];
      end else if (sl_rvalid && m_if.rready)
        sl_rvalid <= 1'b0;
      if (m_if.awvalid && m_if.awready)
        sl_awaddr <= m_if.awaddr;
      if (m_if.wvalid && m_if.wready) begin
        mem[sl_awaddr[5:2]] <= m_if.wdata;
        if (!sl_no_b) sl_bvalid <= 1'b1;
      end else if (sl_bvalid && m_if.bready)
        sl_bvalid <= 1'b0;
    end
  end

  int   gq [$];
  int   cur_len, last_len, tocnt, leak, w_early;
  logic pbusy, to_bready;

  initial begin
    cur_len = 0; last_len = 0; tocnt = 0;
    leak = 0; w_early = 0; pbusy = 1'b0; to_bready = 1'b0;
  end

  always @(negedge aclk) begin
    if (areset_n) begin
      if (busy && !pbusy) gq.push_back(int'(gnt_id));
      if (busy) cur_len++;
      else if (pbusy) begin
        last_len = cur_len;
        cur_len  = 0;
      end
      if (m_if.wvalid && m_if.awvalid) w_early++;
      if (timeout_o) begin
        tocnt++;
        if (m_if.bready) to_bready = 1'b1;
      end
      for (int i = 0; i < 2; i++)
        if (int'(gnt_id) != i &&
            (s_arready[i] | s_awready[i] | s_wready[i] |
             s_rvalid[i] | s_bvalid[i] | (s_rdata[i] != 0)))
          leak++;
    end else
      cur_len = 0;
    pbusy = busy && areset_n;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input int m, input logic [31:0] a,
                    output logic [31:0] d, output logic [1:0] r);
    int n;
    @(negedge aclk);
    m_araddr[m]  = a;
    m_arvalid[m] = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!s_arready[m] && n < 100);
    chk("rd_ar_wait", {31'd0, s_arready[m]}, 1);
    @(posedge aclk); #1;
    m_arvalid[m] = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!s_rvalid[m] && n < 100);
    chk("rd_r_wait", {31'd0, s_rvalid[m]}, 1);
    d = s_rdata[m];
    r = s_rresp[m];
    @(posedge aclk); #1;
  endtask

  task automatic wr(input int m, input logic [31:0] a,
                    input logic [31:0] dat, output logic [1:0] r,
                    input int lim);
    int n;
    @(negedge aclk);
    m_awaddr[m]  = a;
    m_awvalid[m] = 1'b1;
    m_wdata[m]   = dat;
    m_wvalid[m]  = 1'b1;
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!s_awready[m] && n < 100);
    chk("wr_aw_wait", {31'd0, s_awready[m]}, 1);
    @(posedge aclk); #1;
    m_awvalid[m] = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!s_wready[m] && n < 100);
    chk("wr_w_wait", {31'd0, s_wready[m]}, 1);
    @(posedge aclk); #1;
    m_wvalid[m] = 1'b0;
    n = 0;
    do begin @(negedge aclk); n++; end
    while (!s_bvalid[m] && n < lim);
    chk("wr_b_wait", {31'd0, s_bvalid[m]}, 1);
    r = s_bresp[m];
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset_n = 1'b0;
    repeat (2) @(negedge aclk);
    areset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "bench hung");
  end

  logic [31:0] d, d0, d1;
  logic [1:0]  r, r0, r1;
  logic        m0_done, early;
  int          n2, base, to0;

  initial begin
    areset_n   = 1'b0;
    m_arvalid  = '0;
    m_awvalid  = '0;
    m_wvalid   = '0;
    m_rready   = 2'b11;
    m_bready   = 2'b11;
    sl_awready = 1'b1;
    sl_no_b    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_araddr[i] = '0;
      m_awaddr[i] = '0;
      m_wdata[i]  = '0;
    end
    repeat (3) @(negedge aclk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_gnt", {31'd0, gnt_id}, 0);
    chk("rst_timeout", {31'd0, timeout_o}, 0);
    chk("rst_m_valid", {29'd0, m_if.arvalid, m_if.awvalid, m_if.wvalid}, 0);
    chk("rst_m_ready", {30'd0, m_if.rready, m_if.bready}, 0);
    chk("rst_s_arready", {30'd0, s_arready}, 0);
    areset_n = 1'b1;

    rd(0, 32'h04, d, r);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", {30'd0, r}, {30'd0, RESP_OKAY});
    chk("t1_gnt", {31'd0, gnt_id}, 0);
    @(negedge aclk); #1;
    chk("t1_busy_len", last_len, 2);

    do_reset();
    base    = gq.size();
    m0_done = 1'b0;
    early   = 1'b0;
    n2      = 0;
    fork
      begin rd(0, 32'h04, d0, r0); m0_done = 1'b1; end
      rd(1, 32'h0C, d1, r1);
      while (!m0_done && n2 < 100) begin
        @(negedge aclk);
        if (s_arready[1]) early = 1'b1;
        n2++;
      end
    join
    chk("t2_d0", d0, 32'hDEADBEEF);
    chk("t2_d1", d1, 32'hCAFEF00D);
    chk("t2_ngnt", gq.size() - base, 2);
    chk("t2_g0", gq[base], 0);
    chk("t2_g1", gq[base+1], 1);
    chk("t2_m1_ar_held", {31'd0, early}, 0);

    sl_awready = 1'b0;
    fork
      wr(1, 32'h08, 32'h12345678, r, 50);
      begin
        repeat (3) @(negedge aclk);
        chk("t3_aw_stall", {31'd0, m_if.awvalid}, 1);
        chk("t3_w_hold", {31'd0, m_if.wvalid}, 0);
        sl_awready = 1'b1;
      end
    join
    chk("t3_bresp", {30'd0, r}, {30'd0, RESP_OKAY});
    rd(0, 32'h08, d, r);
    chk("t3_rdata", d, 32'h12345678);
    chk("t3_no_early_w", w_early, 0);

    base = gq.size();
    fork
      for (int k = 0; k < 4; k++) begin
        logic [31:0] dk;
        logic [1:0]  rk;
        rd(0, 32'h0C, dk, rk);
        chk("t4_rdata", dk, 32'hCAFEF00D);
      end
      for (int k = 0; k < 4; k++) begin
        logic [1:0] rk;
        wr(1, 32'h10 + 32'(4*k), 32'hA5000000 + 32'(k), rk, 50);
        chk("t4_bresp", {30'd0, rk}, {30'd0, RESP_OKAY});
      end
    join
    chk("t4_ngnt", gq.size() - base, 8);
    for (int i = 0; i < 8; i++)
      chk("t4_gnt_alt", gq[base+i], (i % 2 == 0) ? 32'd1 : 32'd0);
    rd(0, 32'h1C, d, r);
    chk("t4_rdback", d, 32'hA5000003);

    @(negedge aclk);
    m_awaddr[1]  = 32'h20;
    m_wdata[1]   = 32'h0BADF00D;
    m_awvalid[1] = 1'b1;
    n2 = 0;
    do begin @(negedge aclk); n2++; end
    while (!s_awready[1] && n2 < 50);
    chk("t5_aw", {31'd0, s_awready[1]}, 1);
    @(posedge aclk); #1;
    m_awvalid[1] = 1'b0;
    @(negedge aclk);
    chk("t5_busy_pre", {31'd0, busy}, 1);
    chk("t5_gnt_pre", {31'd0, gnt_id}, 1);
    areset_n    = 1'b0;
    m_wvalid[1] = 1'b1;
    @(negedge aclk);
    chk("t5_busy", {31'd0, busy}, 0);
    chk("t5_gnt", {31'd0, gnt_id}, 0);
    chk("t5_s_wready", {30'd0, s_wready}, 0);
    chk("t5_s_awready", {30'd0, s_awready}, 0);
    chk("t5_m_sigs", {27'd0, m_if.arvalid, m_if.awvalid, m_if.wvalid,
                      m_if.rready, m_if.bready}, 0);
    m_wvalid[1] = 1'b0;
    areset_n    = 1'b1;
    rd(1, 32'h04, d, r);
    chk("t5_rdata", d, 32'hDEADBEEF);
    chk("t5_gnt_new", {31'd0, gnt_id}, 1);

`ifdef AXIL_ARB_TIMEOUT_EN
    sl_no_b = 1'b1;
    to0     = tocnt;
    wr(0, 32'h24, 32'h55, r, 400);
    chk("t6_bresp", {30'd0, r}, {30'd0, RESP_SLVERR});
    @(negedge aclk); #1;
    chk("t6_pulse", tocnt - to0, 1);
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_bready_held", {31'd0, to_bready}, 0);
    sl_no_b = 1'b0;
`endif

    chk("no_leak", leak, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
